// File: rtl/regfile_reader_if.sv
// Write/read bus for regfile_reader.
// One write port plus two registered read ports.
interface regfile_reader_if #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 5
);
  logic              wrenable;
  logic [AWIDTH-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              rena;
  logic [AWIDTH-1:0] raddra;
  logic [WIDTH-1:0]  rdataa;
  logic              rvalida;
  logic              renb;
  logic [AWIDTH-1:0] raddrb;
  logic [WIDTH-1:0]  rdatab;
  logic              rvalidb;

  modport master (
    output wrenable, waddr, wdata,
    output rena, raddra, renb, raddrb,
    input  rdataa, rvalida, rdatab, rvalidb
  );

  modport slave (
    input  wrenable, waddr, wdata,
    input  rena, raddra, renb, raddrb,
    output rdataa, rvalida, rdatab, rvalidb
  );
endinterface

// File: rtl/regfile_reader.sv
// Register file, one write port, two registered read ports.
// Entry 0 reads zero; same-edge writes forward to readers.
module regfile_reader #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int AWIDTH = 5
) (
  input logic            clk,
  input logic            reset_n,
  regfile_reader_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  state_t           state_a;
  state_t           state_b;

  function automatic logic [WIDTH-1:0] pick(
    input logic [AWIDTH-1:0] a
  );
    logic fwd;
    logic zero;
    zero = (a == '0);
    fwd  = bus.wrenable && (bus.waddr == a) && !zero;
    unique case (1'b1)
      zero:    pick = '0;
      fwd:     pick = bus.wdata;
      default: pick = mem[a];
    endcase
  endfunction

  // Read data each port would capture on this edge.
  always_comb begin
    next_a = pick(bus.raddra);
    next_b = pick(bus.raddrb);
  end

  // Storage; entry 0 is never written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.wrenable && bus.waddr != '0) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  // Port A FSM; data held while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_a <= IDLE;
      rdata_a <= '0;
    end else if (bus.rena) begin
      state_a <= VALID;
      rdata_a <= next_a;
    end else begin
      state_a <= IDLE;
    end
  end

  // Port B FSM; data held while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_b <= IDLE;
      rdata_b <= '0;
    end else if (bus.renb) begin
      state_b <= VALID;
      rdata_b <= next_b;
    end else begin
      state_b <= IDLE;
    end
  end

  assign bus.rdataa  = rdata_a;
  assign bus.rvalida = (state_a == VALID);
  assign bus.rdatab  = rdata_b;
  assign bus.rvalidb = (state_b == VALID);

endmodule

// File: tb/tb_regfile_reader.sv
// Self-checking bench for regfile_reader.
// Reference model plus per-port expected-data queues.
module tb_regfile_reader;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  logic [31:0] mdl [32];
  logic [31:0] qa [$];
  logic [31:0] qb [$];
  logic [31:0] hold_a;
  logic [31:0] hold_b;
  logic [31:0] ea;
  logic [31:0] eb;

  regfile_reader_if #(.WIDTH(32), .AWIDTH(5)) bus ();

  regfile_reader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_rd(
    input logic       we,
    input logic [4:0] wa,
    input logic [31:0] wd,
    input logic [4:0] ra
  );
    if (ra == 5'd0) return 32'h0;
    if (we && wa == ra) return wd;
    return mdl[ra];
  endfunction

  task automatic step(
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] wd,
    input logic        ra_en,
    input logic [4:0]  ra,
    input logic        rb_en,
    input logic [4:0]  rb
  );
    logic [31:0] x;
    bus.wrenable = we;
    bus.waddr    = wa;
    bus.wdata    = wd;
    bus.rena     = ra_en;
    bus.raddra   = ra;
    bus.renb     = rb_en;
    bus.raddrb   = rb;
    if (ra_en) begin
      x = model_rd(we, wa, wd, ra);
      qa.push_back(x);
      hold_a = x;
    end
    if (rb_en) begin
      x = model_rd(we, wa, wd, rb);
      qb.push_back(x);
      hold_b = x;
    end
    @(posedge clk);
    #1;
    if (we && wa != 5'd0) mdl[wa] = wd;
    bus.wrenable = 1'b0;
    bus.rena     = 1'b0;
    bus.renb     = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    qa.delete();
    qb.delete();
    hold_a = 32'h0;
    hold_b = 32'h0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.rvalida !== 1'b0 || bus.rdataa !== 32'h0 ||
        bus.rvalidb !== 1'b0 || bus.rdatab !== 32'h0) begin
      failures++;
      $display("FAIL reset_init a=%h/%b b=%h/%b exp 0/0",
        bus.rdataa, bus.rvalida, bus.rdatab, bus.rvalidb);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 5, 32'hDEADBEEF, 1, 5, 0, 0);
    ea = qa.pop_front();
    checks++;
    if (bus.rvalida !== 1'b1 || bus.rdataa !== ea) begin
      failures++;
      $display("FAIL reset_pre rdataa=%h rvalida=%b exp %h/1",
        bus.rdataa, bus.rvalida, ea);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.rvalida !== 1'b0 || bus.rdataa !== 32'h0) begin
      failures++;
      $display("FAIL reset_async rdataa=%h rvalida=%b exp 0/0",
        bus.rdataa, bus.rvalida);
    end
    clear_model();
    bus.wrenable = 1'b1;
    bus.waddr    = 5'd6;
    bus.wdata    = 32'hCAFE0000;
    bus.rena     = 1'b1;
    bus.raddra   = 5'd6;
    @(posedge clk);
    #1;
    checks++;
    if (bus.rvalida !== 1'b0 || bus.rdataa !== 32'h0) begin
      failures++;
      $display("FAIL reset_held rdataa=%h rvalida=%b exp 0/0",
        bus.rdataa, bus.rvalida);
    end
    bus.wrenable = 1'b0;
    bus.rena     = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0, 1, 5, 1, 6);
    ea = qa.pop_front();
    eb = qb.pop_front();
    checks++;
    if (bus.rvalida !== 1'b1 || bus.rdataa !== ea ||
        bus.rvalidb !== 1'b1 || bus.rdatab !== eb) begin
      failures++;
      $display("FAIL reset_after a=%h/%b b=%h/%b exp %h %h",
        bus.rdataa, bus.rvalida, bus.rdatab, bus.rvalidb,
        ea, eb);
    end
  endtask

  task automatic test_basic();
    step(1, 7, 32'h12345678, 0, 0, 0, 0);
    step(0, 0, 0, 1, 7, 0, 0);
    ea = qa.pop_front();
    checks++;
    if (bus.rvalida !== 1'b1 || bus.rdataa !== ea) begin
      failures++;
      $display("FAIL basic_read rdataa=%h rvalida=%b exp %h/1",
        bus.rdataa, bus.rvalida, ea);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.rvalida !== 1'b0 || bus.rdataa !== hold_a) begin
      failures++;
      $display("FAIL basic_drop rdataa=%h rvalida=%b exp %h/0",
        bus.rdataa, bus.rvalida, hold_a);
    end
  endtask

  task automatic test_zero();
    step(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    ea = qa.pop_front();
    eb = qb.pop_front();
    checks++;
    if (bus.rdataa !== ea || bus.rdatab !== eb ||
        bus.rvalida !== 1'b1 || bus.rvalidb !== 1'b1) begin
      failures++;
      $display("FAIL zero_reg a=%h b=%h exp %h %h",
        bus.rdataa, bus.rdatab, ea, eb);
    end
    step(1, 0, 32'h13572468, 1, 0, 1, 0);
    ea = qa.pop_front();
    eb = qb.pop_front();
    checks++;
    if (bus.rdataa !== ea || bus.rdatab !== eb) begin
      failures++;
      $display("FAIL zero_fwd a=%h b=%h exp %h %h",
        bus.rdataa, bus.rdatab, ea, eb);
    end
  endtask

  task automatic test_forward();
    step(1, 3, 32'hAAAA0000, 0, 0, 0, 0);
    step(1, 4, 32'h00000001, 0, 0, 0, 0);
    step(1, 3, 32'h5555FFFF, 1, 3, 1, 4);
    ea = qa.pop_front();
    eb = qb.pop_front();
    checks++;
    if (bus.rdataa !== ea || bus.rdatab !== eb) begin
      failures++;
      $display("FAIL fwd a=%h b=%h exp %h %h",
        bus.rdataa, bus.rdatab, ea, eb);
    end
    step(1, 8, 32'h0BADF00D, 1, 8, 1, 8);
    ea = qa.pop_front();
    eb = qb.pop_front();
    checks++;
    if (bus.rdataa !== ea || bus.rdatab !== eb ||
        bus.rdataa !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL fwd_both a=%h b=%h exp %h %h",
        bus.rdataa, bus.rdatab, ea, eb);
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i < 32; i++)
      step(1, 5'(i), 32'(i) * 32'h01010101, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 1, 5'(i), 1, 5'(31 - i));
      ea = qa.pop_front();
      eb = qb.pop_front();
      checks++;
      if (bus.rvalida !== 1'b1 || bus.rdataa !== ea ||
          bus.rvalidb !== 1'b1 || bus.rdatab !== eb) begin
        failures++;
        $display("FAIL stream[%0d] a=%h/%b b=%h/%b exp %h %h",
          i, bus.rdataa, bus.rvalida, bus.rdatab,
          bus.rvalidb, ea, eb);
      end
    end
  endtask

  task automatic test_hold();
    step(1, 9, 32'h9, 0, 0, 0, 0);
    step(0, 0, 0, 1, 9, 0, 0);
    ea = qa.pop_front();
    checks++;
    if (bus.rdataa !== ea) begin
      failures++;
      $display("FAIL hold_read rdataa=%h exp %h", bus.rdataa, ea);
    end
    step(1, 9, 32'h99, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.rdataa !== hold_a || bus.rvalida !== 1'b0) begin
      failures++;
      $display("FAIL hold_notrack rdataa=%h rvalida=%b exp %h/0",
        bus.rdataa, bus.rvalida, hold_a);
    end
    step(0, 0, 0, 1, 9, 0, 0);
    ea = qa.pop_front();
    checks++;
    if (bus.rdataa !== ea || bus.rdataa !== 32'h99) begin
      failures++;
      $display("FAIL hold_reread rdataa=%h exp %h", bus.rdataa, ea);
    end
  endtask

  task automatic test_back_to_back();
    logic        we, ra_en, rb_en;
    logic [4:0]  wa, ra, rb;
    logic [31:0] wd;
    for (int i = 0; i < 200; i++) begin
      we    = 1'($urandom_range(0, 1));
      wa    = 5'($urandom_range(0, 31));
      wd    = $urandom;
      ra_en = 1'($urandom_range(0, 3) != 0);
      rb_en = 1'($urandom_range(0, 3) != 0);
      ra    = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      rb    = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      step(we, wa, wd, ra_en, ra, rb_en, rb);
      ea = ra_en ? qa.pop_front() : hold_a;
      eb = rb_en ? qb.pop_front() : hold_b;
      checks++;
      if (bus.rvalida !== ra_en || bus.rdataa !== ea ||
          bus.rvalidb !== rb_en || bus.rdatab !== eb) begin
        failures++;
        $display("FAIL rand[%0d] a=%h/%b b=%h/%b exp %h/%b %h/%b",
          i, bus.rdataa, bus.rvalida, bus.rdatab, bus.rvalidb,
          ea, ra_en, eb, rb_en);
      end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset_n      = 1'b0;
    bus.wrenable = 1'b0;
    bus.waddr    = '0;
    bus.wdata    = '0;
    bus.rena     = 1'b0;
    bus.raddra   = '0;
    bus.renb     = 1'b0;
    bus.raddrb   = '0;
    clear_model();
    #12;
    test_reset();
    test_basic();
    test_zero();
    test_forward();
    test_stream();
    test_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
